alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer in front of a combinational ALU; MUL/DIV get a longer execute window.
// Optional op counter enabled by defining ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
    parameter int WIDTH      = 128,
    parameter int MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_shift,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_sign,
    output logic             out_illegal,
    output logic             out_divzero,
`ifdef ALU_SEQ_STATS_EN
    output logic [31:0]      op_count,
`endif
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // EXEC  | ALU operands held, counter running down to the capture cycle
    // DONE  | response held until out_ready; a new request may be taken here
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_MUL      = 4'd2;
    localparam logic [3:0] OP_DIV      = 4'd6;
    localparam logic [3:0] LOAD_MULDIV = 4'(MULDIV_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       accept;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_carry      <= 1'b0;
            out_zero       <= 1'b0;
            out_sign       <= 1'b0;
            out_illegal    <= 1'b0;
            out_divzero    <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        out_result  <= alu_result;
                        out_carry   <= alu_carry;
                        out_zero    <= alu_zero;
                        out_sign    <= alu_sign;
                        out_illegal <= (alu_opcode >= 4'd12);
                        out_divzero <= (alu_opcode == OP_DIV) && (alu_input2 == '0);
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
            // Acceptance overrides the DONE->IDLE move so back-to-back ops skip the idle cycle.
            if (accept) begin
                alu_opcode     <= in_opcode;
                alu_input1     <= in_a;
                alu_input2     <= in_b;
                alu_shiftValue <= in_shift;
                cnt            <= (in_opcode == OP_MUL || in_opcode == OP_DIV) ? LOAD_MULDIV : 4'd0;
                state          <= EXEC;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            op_count <= '0;
        else if (out_valid && out_ready)
            op_count <= op_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small combinational ALU model in place of the real ALU.
// Latency is counted with the accept edge as cycle 1 (single-cycle op = 2, MUL/DIV = MULDIV_LAT+1).
module tb_alu_op_sequencer;
    localparam int W   = 128;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_opcode = '0;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [4:0]    in_shift = '0;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_input1, alu_input2;
    logic [4:0]    alu_shiftValue;
    logic [W-1:0]  alu_result;
    logic          alu_carry, alu_zero, alu_sign;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_carry, out_zero, out_sign, out_illegal, out_divzero;
    logic          busy;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0]   op_count;
    int            exp_ops = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_shift(in_shift),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
        .out_sign(out_sign), .out_illegal(out_illegal), .out_divzero(out_divzero),
`ifdef ALU_SEQ_STATS_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    // ALU stand-in: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 DIV, 7 SHL, 8..11 pass a, 12..15 zero.
    logic [W:0] sum;
    always_comb begin
        sum        = '0;
        alu_carry  = 1'b0;
        alu_result = '0;
        case (alu_opcode)
            4'd0: begin
                sum        = {1'b0, alu_input1} + {1'b0, alu_input2};
                alu_result = sum[W-1:0];
                alu_carry  = sum[W];
            end
            4'd1: alu_result = alu_input1 - alu_input2;
            4'd2: alu_result = alu_input1 * alu_input2;
            4'd3: alu_result = alu_input1 & alu_input2;
            4'd4: alu_result = alu_input1 | alu_input2;
            4'd5: alu_result = alu_input1 ^ alu_input2;
            4'd6: alu_result = (alu_input2 == '0) ? '0 : alu_input1 / alu_input2;
            4'd7: alu_result = alu_input1 << alu_shiftValue;
            4'd8, 4'd9, 4'd10, 4'd11: alu_result = alu_input1;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
        alu_sign = alu_result[W-1];
    end

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         carry, zero, sign, illegal, divzero;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Call right after the accept edge; returns latency with the accept edge counted as 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            chk("in_ready_exec", W'(in_ready), W'(0));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("out_valid_seen", W'(out_valid), W'(1));
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [4:0] sh);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_shift  = sh;
    endtask

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
        chk({vecs[i].name, "_in_ready"}, W'(in_ready), W'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk({vecs[i].name, "_lat"}, W'(lat), W'(vecs[i].lat));
        chk({vecs[i].name, "_result"}, out_result, vecs[i].res);
        chk({vecs[i].name, "_flags"},
            W'({out_carry, out_zero, out_sign, out_illegal, out_divzero}),
            W'({vecs[i].carry, vecs[i].zero, vecs[i].sign, vecs[i].illegal, vecs[i].divzero}));
        chk({vecs[i].name, "_alu_op"}, W'(alu_opcode), W'(vecs[i].op));
        chk({vecs[i].name, "_alu_a"}, alu_input1, vecs[i].a);
        @(posedge clk);
`ifdef ALU_SEQ_STATS_EN
        exp_ops++;
`endif
        @(negedge clk);
        chk({vecs[i].name, "_drained"}, W'({out_valid, busy}), W'(0));
    endtask

    initial begin
        int lat;
        logic [W-1:0] ones;
        ones = '1;

        vecs[0] = '{"xor",     4'd5,  W'(16'hF0F0), W'(16'h00FF), 5'd0, W'(16'hF00F), 0, 0, 0, 0, 0, 2};
        vecs[1] = '{"mul",     4'd2,  W'(3),        W'(5),        5'd0, W'(15),       0, 0, 0, 0, 0, LAT+1};
        vecs[2] = '{"div0",    4'd6,  W'(100),      W'(0),        5'd0, W'(0),        0, 1, 0, 0, 1, LAT+1};
        vecs[3] = '{"div7",    4'd6,  W'(100),      W'(7),        5'd0, W'(14),       0, 0, 0, 0, 0, LAT+1};
        vecs[4] = '{"add",     4'd0,  W'(5),        W'(7),        5'd0, W'(12),       0, 0, 0, 0, 0, 2};
        vecs[5] = '{"addwrap", 4'd0,  ones,         W'(1),        5'd0, W'(0),        1, 1, 0, 0, 0, 2};
        vecs[6] = '{"sub_neg", 4'd1,  W'(0),        W'(1),        5'd0, ones,         0, 0, 1, 0, 0, 2};
        vecs[7] = '{"ill13",   4'd13, W'(9),        W'(9),        5'd0, W'(0),        0, 1, 0, 1, 0, 2};
        vecs[8] = '{"and",     4'd3,  W'(8'hFF),    W'(8'h0F),    5'd0, W'(8'h0F),    0, 0, 0, 0, 0, 2};
        vecs[9] = '{"shl",     4'd7,  W'(1),        W'(0),        5'd31, W'(64'h8000_0000), 0, 0, 0, 0, 0, 2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", W'({out_valid, busy, out_carry, out_zero, out_sign, out_illegal, out_divzero}), W'(0));
        chk("rst_alu", alu_input1 | alu_input2 | W'(alu_opcode) | W'(alu_shiftValue), W'(0));
        chk("rst_result", out_result, W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Illegal op then AND taken back-to-back in DONE
        @(negedge clk);
        out_ready = 1'b1;
        drive_req(4'd13, W'(5), W'(6), 5'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk("b2b_ill_flag", W'(out_illegal), W'(1));
        chk("b2b_ill_res", out_result, W'(0));
        drive_req(4'd3, W'(8'hFF), W'(8'h0F), 5'd0);
        chk("b2b_in_ready_done", W'(in_ready), W'(1));
        @(posedge clk);
`ifdef ALU_SEQ_STATS_EN
        exp_ops++;
`endif
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk("b2b_and_lat", W'(lat), W'(2));
        chk("b2b_and_res", out_result, W'(8'h0F));
        chk("b2b_and_ill", W'(out_illegal), W'(0));
        @(posedge clk);
`ifdef ALU_SEQ_STATS_EN
        exp_ops++;
`endif
        @(negedge clk);
        chk("b2b_idle", W'(busy), W'(0));

        // Backpressure: response held for 6 cycles, new request ignored meanwhile
        out_ready = 1'b0;
        drive_req(4'd5, W'(16'hF0F0), W'(16'h00FF), 5'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        drive_req(4'd0, W'(1), W'(1), 5'd3);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", W'(out_valid), W'(1));
            chk("stall_result", out_result, W'(16'hF00F));
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_alu_op", W'(alu_opcode), W'(5));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
`ifdef ALU_SEQ_STATS_EN
        exp_ops++;
`endif
        @(negedge clk);
        chk("stall_release", W'({out_valid, busy}), W'(0));
`ifdef ALU_SEQ_STATS_EN
        chk("op_count", W'(op_count), W'(exp_ops));
`endif

        // Reset two cycles into a MUL
        drive_req(4'd2, W'(3), W'(5), 5'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_outputs", W'({out_valid, busy, out_illegal, out_divzero, out_zero}), W'(0));
        chk("mrst_alu", alu_input1 | alu_input2 | W'(alu_opcode) | W'(alu_shiftValue), W'(0));
        chk("mrst_in_ready", W'(in_ready), W'(1));
`ifdef ALU_SEQ_STATS_EN
        exp_ops = 0;
        chk("mrst_op_count", W'(op_count), W'(0));
`endif
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("mrst_no_resp", W'({out_valid, busy}), W'(0));
        end
        run_vec(0);
`ifdef ALU_SEQ_STATS_EN
        chk("op_count_end", W'(op_count), W'(exp_ops));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
